// File: rtl/sched_pkg.sv
// Package: sched_pkg
// Purpose : shared state encodings and phase-duration defaults for the
//           sample-memory access scheduler.
// Contents:
//   state_t          IDLE = 0, WRITE = 1, READ = 2, 3 = illegal (recovers to IDLE)
//   DEF_*            default widths, depth and phase durations
package sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_BAD   = 2'd3
   } state_t;

   localparam int DEF_ADDR_W      = 4;
   localparam int DEF_DEPTH       = 16;
   localparam int DEF_IDLE_TICKS  = 5;
   localparam int DEF_WRITE_TICKS = 10;
   localparam int DEF_READ_DWELL  = 2;
   localparam int DEF_TIMER_W     = 8;

endpackage

// File: rtl/phase_timer.sv
// Module : phase_timer
// Purpose: tick counter shared by all scheduler phases. Counts ticks since
//          the last clear and flags when the count equals the terminal value.
// Ports  :
//   clock1Hz  in   1        tick clock, rising edge
//   reset     in   1        asynchronous, active-high; clears the count
//   clear     in   1        synchronous clear (wins over tick)
//   tick      in   1        advance the count by one
//   term      in   TIMER_W  terminal value compared against the count
//   done      out  1        count == term, decoded from the count register
module phase_timer
   import sched_pkg::*;
#(
   parameter int TIMER_W = DEF_TIMER_W
) (
   input  logic               clock1Hz,
   input  logic               reset,
   input  logic               clear,
   input  logic               tick,
   input  logic [TIMER_W-1:0] term,
   output logic               done
);

   logic [TIMER_W-1:0] tcnt;

   always_ff @(posedge clock1Hz or posedge reset) begin
      if (reset) begin
         tcnt <= '0;
      end else if (clear) begin
         tcnt <= '0;
      end else if (tick) begin
         tcnt <= tcnt + 1'b1;
      end
   end

   assign done = (tcnt == term);

endmodule

// File: rtl/mem_access_scheduler.sv
// Module : mem_access_scheduler
// Purpose: sequences a single-port sample memory through IDLE -> WRITE -> READ.
//          WRITE captures one sample per dav-qualified tick into successive
//          addresses; READ replays every captured address, holding each one for
//          READ_DWELL ticks. Owns the phase timer, write/read pointers and the
//          stored-sample count.
// Ports  :
//   clock1Hz  in   1         tick clock, rising edge
//   reset     in   1         asynchronous, active-high
//   dav       in   1         data available, synchronous to clock1Hz
//   mem_en    out  1         memory enable (WRITE or READ)
//   mem_we    out  1         memory write enable (WRITE and dav, same cycle)
//   mem_addr  out  ADDR_W    memory address (wr_ptr in WRITE, rd_ptr in READ)
//   count     out  ADDR_W+1  words captured in the last WRITE phase
//   phase     out  2         0 = IDLE, 1 = WRITE, 2 = READ (state register)
//
// Handshake: dav is a one-cycle qualifier with no back-pressure. In WRITE every
// rising edge that sees dav = 1 stores exactly one word; dav is ignored in IDLE
// and READ.
module mem_access_scheduler
   import sched_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DEPTH       = DEF_DEPTH,
   parameter int IDLE_TICKS  = DEF_IDLE_TICKS,
   parameter int WRITE_TICKS = DEF_WRITE_TICKS,
   parameter int READ_DWELL  = DEF_READ_DWELL,
   parameter int TIMER_W     = DEF_TIMER_W
) (
   input  logic              clock1Hz,
   input  logic              reset,
   input  logic              dav,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [ADDR_W:0]   count,
   output logic [1:0]        phase
);

   localparam logic [TIMER_W-1:0] IDLE_TERM  = TIMER_W'(IDLE_TICKS - 1);
   localparam logic [TIMER_W-1:0] WRITE_TERM = TIMER_W'(WRITE_TICKS - 1);
   localparam logic [TIMER_W-1:0] READ_TERM  = TIMER_W'(READ_DWELL - 1);
   localparam logic [ADDR_W:0]    DEPTH_M1   = (ADDR_W + 1)'(DEPTH - 1);
   localparam logic [ADDR_W:0]    ONE        = (ADDR_W + 1)'(1);

   state_t              state;
   state_t              state_n;
   logic [ADDR_W-1:0]   wr_ptr;
   logic [ADDR_W-1:0]   rd_ptr;
   logic [ADDR_W:0]     count_q;

   logic                t_done;
   logic                t_clear;
   logic [TIMER_W-1:0]  t_term;
   logic                rd_adv;
   logic                full_hit;

   // One timer serves every phase; its terminal value follows the state.
   phase_timer #(
      .TIMER_W (TIMER_W)
   ) u_timer (
      .clock1Hz (clock1Hz),
      .reset    (reset),
      .clear    (t_clear),
      .tick     (1'b1),
      .term     (t_term),
      .done     (t_done)
   );

   // Next-state and timer control.
   always_comb begin
      t_term   = '0;
      state_n  = ST_IDLE;
      rd_adv   = 1'b0;
      full_hit = 1'b0;
      t_clear  = 1'b0;
      case (state)
         ST_IDLE: begin
            t_term  = IDLE_TERM;
            state_n = t_done ? ST_WRITE : ST_IDLE;
         end
         ST_WRITE: begin
            t_term   = WRITE_TERM;
            // This write fills the last free word.
            full_hit = dav && (count_q == DEPTH_M1);
            if (full_hit || t_done) begin
               // Post-edge count is non-zero if anything was or is being written.
               state_n = (dav || (count_q != '0)) ? ST_READ : ST_IDLE;
            end else begin
               state_n = ST_WRITE;
            end
         end
         ST_READ: begin
            t_term  = READ_TERM;
            state_n = ST_READ;
            if (t_done) begin
               if ({1'b0, rd_ptr} == (count_q - ONE)) begin
                  state_n = ST_IDLE;
               end else begin
                  rd_adv = 1'b1;
               end
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
      // Timer restarts on every phase change and every READ address advance.
      t_clear = (state_n != state) || rd_adv;
   end

   // State, pointers and count.
   always_ff @(posedge clock1Hz or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         state <= state_n;
         case (state)
            ST_IDLE: begin
               if (t_done) begin
                  wr_ptr  <= '0;
                  count_q <= '0;
               end
            end
            ST_WRITE: begin
               if (dav) begin
                  wr_ptr  <= wr_ptr + 1'b1;
                  count_q <= count_q + 1'b1;
               end
               if (state_n == ST_READ) begin
                  rd_ptr <= '0;
               end
            end
            ST_READ: begin
               if (rd_adv) begin
                  rd_ptr <= rd_ptr + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Output decode. Only mem_we depends on dav; the rest come from registers.
   always_comb begin
      mem_en   = 1'b0;
      mem_we   = 1'b0;
      mem_addr = '0;
      phase    = 2'd0;
      case (state)
         ST_WRITE: begin
            mem_en   = 1'b1;
            mem_we   = dav;
            mem_addr = wr_ptr;
            phase    = 2'd1;
         end
         ST_READ: begin
            mem_en   = 1'b1;
            mem_addr = rd_ptr;
            phase    = 2'd2;
         end
         default: begin
         end
      endcase
   end

   assign count = count_q;

endmodule

// File: tb/tb_mem_access_scheduler.sv
// Testbench: tb_mem_access_scheduler
// Directed vectors against two instances: u_dut with default DEPTH = 16 and
// u_dut4 with DEPTH = 4. Inputs change on the falling edge; outputs are
// sampled 1 time unit later, well away from the rising edge.
module tb_mem_access_scheduler;

   // ---------------- clock / reset ----------------
   logic       clock1Hz = 1'b0;
   logic       reset    = 1'b0;
   logic       dav      = 1'b0;
   logic       dav4     = 1'b0;

   logic       mem_en,  mem_we;
   logic [3:0] mem_addr;
   logic [4:0] count;
   logic [1:0] phase;

   logic       mem_en4, mem_we4;
   logic [3:0] mem_addr4;
   logic [4:0] count4;
   logic [1:0] phase4;

   always #5 clock1Hz = ~clock1Hz;

   mem_access_scheduler u_dut (
      .clock1Hz (clock1Hz),
      .reset    (reset),
      .dav      (dav),
      .mem_en   (mem_en),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .count    (count),
      .phase    (phase)
   );

   mem_access_scheduler #(
      .DEPTH (4)
   ) u_dut4 (
      .clock1Hz (clock1Hz),
      .reset    (reset),
      .dav      (dav4),
      .mem_en   (mem_en4),
      .mem_we   (mem_we4),
      .mem_addr (mem_addr4),
      .count    (count4),
      .phase    (phase4)
   );

   // ---------------- scoreboard ----------------
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic apply_reset();
      @(posedge clock1Hz);
      #2;
      reset = 1'b1;
      dav   = 1'b0;
      dav4  = 1'b0;
      #1;
      check("rst_en",     mem_en,    0);
      check("rst_we",     mem_we,    0);
      check("rst_addr",   mem_addr,  0);
      check("rst_count",  count,     0);
      check("rst_phase",  phase,     0);
      check("rst_en4",    mem_en4,   0);
      check("rst_addr4",  mem_addr4, 0);
      check("rst_count4", count4,    0);
      check("rst_phase4", phase4,    0);
      @(negedge clock1Hz);
      reset = 1'b0;
   endtask

   task automatic set_in(input logic d, input logic d4);
      dav  = d;
      dav4 = d4;
      #1;
   endtask

   task automatic next_cyc();
      @(negedge clock1Hz);
   endtask

   // Bounded run time.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // Write-phase address table for writes at tcnt 2, 5, 7.
   int t2_addr[10] = '{0, 0, 0, 1, 1, 1, 2, 2, 3, 3};

   // ---------------- stimulus ----------------
   initial begin
      int   w;
      int   r;
      logic d;

      // T1: dav = 0 throughout -> 5 IDLE, 10 WRITE, back to IDLE
      apply_reset();
      for (int k = 0; k < 16; k++) begin
         set_in(1'b0, 1'b0);
         if (k < 5) begin
            check("t1_idle_phase", phase, 0);
            check("t1_idle_en", mem_en, 0);
         end else if (k < 15) begin
            check("t1_wr_phase", phase, 1);
            check("t1_wr_en", mem_en, 1);
            check("t1_wr_we", mem_we, 0);
            check("t1_wr_count", count, 0);
         end else begin
            check("t1_back_idle", phase, 0);
         end
         next_cyc();
      end

      // T2 + T4: writes at tcnt 2, 5, 7; dav high during IDLE and READ
      apply_reset();
      exp_q.push_back(0);
      exp_q.push_back(1);
      exp_q.push_back(2);
      for (int k = 0; k < 22; k++) begin
         if (k < 5) begin
            set_in(1'b1, 1'b0);
            check("t4_idle_phase", phase, 0);
            check("t4_idle_we", mem_we, 0);
            check("t4_idle_addr", mem_addr, 0);
         end else if (k < 15) begin
            w = k - 5;
            d = (w == 2) || (w == 5) || (w == 7);
            set_in(d, 1'b0);
            check("t2_wr_phase", phase, 1);
            check("t2_wr_we", mem_we, d);
            check("t2_wr_addr", mem_addr, t2_addr[w]);
            check("t2_wr_count", count, t2_addr[w]);
            if (mem_we) begin
               if (exp_q.size() > 0) check("t2_we_addr", mem_addr, exp_q.pop_front());
               else check("t2_extra_we", mem_we, 0);
            end
         end else if (k < 21) begin
            r = k - 15;
            set_in(1'b1, 1'b0);
            check("t2_rd_phase", phase, 2);
            check("t4_rd_we", mem_we, 0);
            check("t2_rd_addr", mem_addr, r / 2);
            check("t2_rd_count", count, 3);
         end else begin
            set_in(1'b1, 1'b0);
            check("t2_end_idle", phase, 0);
            check("t4_count_hold", count, 3);
            check("t4_idle_we2", mem_we, 0);
         end
         next_cyc();
      end
      check("t2_all_writes", exp_q.size(), 0);

      // T5: reset mid-READ at rd_ptr = 1
      apply_reset();
      for (int k = 0; k < 17; k++) begin
         set_in((k == 5) || (k == 6), 1'b0);
         next_cyc();
      end
      set_in(1'b0, 1'b0);
      check("t5_pre_phase", phase, 2);
      check("t5_pre_addr", mem_addr, 1);
      check("t5_pre_count", count, 2);
      dav = 1'b1;
      #1;
      reset = 1'b1;
      #1;
      check("t5_async_phase", phase, 0);
      check("t5_async_en", mem_en, 0);
      check("t5_async_addr", mem_addr, 0);
      check("t5_async_count", count, 0);
      check("t5_async_we", mem_we, 0);
      @(negedge clock1Hz);
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         set_in(1'b0, 1'b0);
         check("t5_idle_len", phase, (k < 5) ? 0 : 1);
         next_cyc();
      end

      // T3: DEPTH = 4, dav held high from WRITE entry
      apply_reset();
      for (int k = 0; k < 18; k++) begin
         if (k < 5) begin
            set_in(1'b0, 1'b0);
            check("t3_idle_phase", phase4, 0);
         end else if (k < 9) begin
            w = k - 5;
            set_in(1'b0, 1'b1);
            check("t3_wr_phase", phase4, 1);
            check("t3_wr_we", mem_we4, 1);
            check("t3_wr_addr", mem_addr4, w);
            check("t3_wr_count", count4, w);
         end else if (k < 17) begin
            r = k - 9;
            set_in(1'b0, 1'b1);
            check("t3_rd_phase", phase4, 2);
            check("t3_rd_we", mem_we4, 0);
            check("t3_rd_count", count4, 4);
            check("t3_rd_addr", mem_addr4, r / 2);
         end else begin
            set_in(1'b0, 1'b0);
            check("t3_end_idle", phase4, 0);
            check("t3_end_count", count4, 4);
         end
         next_cyc();
      end

      // T6: DEPTH-th write lands on the last WRITE tick
      apply_reset();
      for (int k = 0; k < 24; k++) begin
         if (k < 5) begin
            set_in(1'b0, 1'b0);
            check("t6_idle_phase", phase4, 0);
         end else if (k < 15) begin
            w = k - 5;
            d = (w >= 6);
            set_in(1'b0, d);
            check("t6_wr_phase", phase4, 1);
            check("t6_wr_we", mem_we4, d);
            check("t6_wr_addr", mem_addr4, (w < 6) ? 0 : w - 6);
            check("t6_wr_count", count4, (w < 6) ? 0 : w - 6);
         end else if (k < 23) begin
            r = k - 15;
            set_in(1'b0, 1'b0);
            check("t6_rd_phase", phase4, 2);
            check("t6_rd_count", count4, 4);
            check("t6_rd_addr", mem_addr4, r / 2);
         end else begin
            set_in(1'b0, 1'b0);
            check("t6_end_idle", phase4, 0);
         end
         next_cyc();
      end

      // ---------------- final report ----------------
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
